// File: rtl/fsic_wb_pkg.sv
// Shared types and constants for the FSIC Wishbone request arbiter slice.
package fsic_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } wb_state_t;

  localparam int NUM_REQ = 2;
  localparam int GNT_W   = 1;
  localparam int SEL_W   = 4;

  localparam logic [31:0] FSIC_AA_BASE   = 32'h3000_0000;
  localparam logic [31:0] FSIC_MBOX_BASE = 32'h3000_2000;
  localparam logic [31:0] FSIC_IS_BASE   = 32'h3000_3000;

  function automatic logic [NUM_REQ-1:0] req_onehot(input logic [GNT_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/wb_req_arbiter_rr_pick.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the
// requester that was not granted last.
module wb_rr_pick
  import fsic_wb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [GNT_W-1:0]   i_last,
  output logic [GNT_W-1:0]   o_grant,
  output logic               o_valid
);

  always_comb begin
    o_valid = |i_req;
    o_grant = '0;
    if (&i_req) begin
      o_grant = ~i_last;
    end else if (i_req[1]) begin
      o_grant = GNT_W'(1);
    end
  end

endmodule

// File: rtl/wb_req_arbiter.sv
// Arbitrates two request ports onto one Wishbone master bus, one cycle at a time.
// Optional ack-wait timeout is enabled by defining WB_ACK_TIMEOUT_EN.
module wb_req_arbiter
  import fsic_wb_pkg::*;
#(
  parameter int pADDR_W  = 32,
  parameter int pDATA_W  = 32,
  parameter int pTIMEOUT = 255
) (
  input  logic                       wb_clk,
  input  logic                       wb_rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*pADDR_W-1:0] req_adr,
  input  logic [NUM_REQ*pDATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*SEL_W-1:0]   req_sel,
  input  logic [NUM_REQ-1:0]         req_we,
  output logic [NUM_REQ-1:0]         done,
  output logic [NUM_REQ-1:0]         err,
  output logic [pDATA_W-1:0]         rdata,
  output logic [pADDR_W-1:0]         wbs_adr,
  output logic [pDATA_W-1:0]         wbs_wdata,
  output logic [SEL_W-1:0]           wbs_sel,
  output logic                       wbs_cyc,
  output logic                       wbs_stb,
  output logic                       wbs_we,
  input  logic                       wbs_ack,
  input  logic [pDATA_W-1:0]         wbs_rdata
);

  if (pTIMEOUT < 1 || pTIMEOUT > 65535) begin : g_ptimeout_range
    $error("wb_req_arbiter: pTIMEOUT must be within 1..65535");
  end

  wb_state_t           r_state;
  logic [GNT_W-1:0]    r_last;
  logic [GNT_W-1:0]    r_grant;
  logic [NUM_REQ-1:0]  r_done;
  logic [pDATA_W-1:0]  r_rdata;
  logic [pADDR_W-1:0]  r_adr;
  logic [pDATA_W-1:0]  r_wdata;
  logic [SEL_W-1:0]    r_sel;
  logic                r_cyc;
  logic                r_stb;
  logic                r_we;
  logic [GNT_W-1:0]    w_grant;
  logic                w_valid;

`ifdef WB_ACK_TIMEOUT_EN
  localparam logic [15:0] TMO_LIMIT = 16'(pTIMEOUT - 1);
  logic [15:0]         r_cnt;
  logic [NUM_REQ-1:0]  r_err;
`endif

  wb_rr_pick u_pick (
    .i_req   (req),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_valid (w_valid)
  );

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      r_state <= IDLE;
      r_last  <= GNT_W'(1);
      r_grant <= '0;
      r_done  <= '0;
      r_rdata <= '0;
      r_adr   <= '0;
      r_wdata <= '0;
      r_sel   <= '0;
      r_cyc   <= 1'b0;
      r_stb   <= 1'b0;
      r_we    <= 1'b0;
`ifdef WB_ACK_TIMEOUT_EN
      r_cnt   <= '0;
      r_err   <= '0;
`endif
    end else begin
      r_done <= '0;
`ifdef WB_ACK_TIMEOUT_EN
      r_err  <= '0;
`endif
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_grant <= w_grant;
            r_last  <= w_grant;
            r_adr   <= req_adr[int'(w_grant)*pADDR_W +: pADDR_W];
            r_wdata <= req_wdata[int'(w_grant)*pDATA_W +: pDATA_W];
            r_sel   <= req_sel[int'(w_grant)*SEL_W +: SEL_W];
            r_we    <= req_we[w_grant];
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
`ifdef WB_ACK_TIMEOUT_EN
            r_cnt   <= '0;
`endif
            r_state <= BUS;
          end
        end
        BUS: begin
          // The requester's own req is not consulted here: a started cycle always completes.
          if (wbs_ack) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_wdata <= '0;
            r_sel   <= '0;
            r_rdata <= wbs_rdata;
            r_done  <= req_onehot(r_grant);
            r_state <= DONE;
          end
`ifdef WB_ACK_TIMEOUT_EN
          else if (r_cnt == TMO_LIMIT) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_wdata <= '0;
            r_sel   <= '0;
            r_rdata <= '0;
            r_done  <= req_onehot(r_grant);
            r_err   <= req_onehot(r_grant);
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
`endif
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign done      = r_done;
  assign rdata     = r_rdata;
  assign wbs_adr   = r_adr;
  assign wbs_wdata = r_wdata;
  assign wbs_sel   = r_sel;
  assign wbs_cyc   = r_cyc;
  assign wbs_stb   = r_stb;
  assign wbs_we    = r_we;

`ifdef WB_ACK_TIMEOUT_EN
  assign err = r_err;
`else
  assign err = '0;
`endif

endmodule

// File: tb/tb_wb_req_arbiter.sv
// Self-checking bench for wb_req_arbiter: directed vector table, multi-cycle
// corner sequences, then randomized traffic against a round-robin model.
module tb_wb_req_arbiter;
  import fsic_wb_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic          wb_clk = 1'b0;
  logic          wb_rst;
  logic [1:0]    req;
  logic [63:0]   req_adr;
  logic [63:0]   req_wdata;
  logic [7:0]    req_sel;
  logic [1:0]    req_we;
  logic [1:0]    done;
  logic [1:0]    err;
  logic [31:0]   rdata;
  logic [31:0]   wbs_adr;
  logic [31:0]   wbs_wdata;
  logic [3:0]    wbs_sel;
  logic          wbs_cyc;
  logic          wbs_stb;
  logic          wbs_we;
  logic          wbs_ack;
  logic [31:0]   wbs_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  wb_req_arbiter #(.pADDR_W(AW), .pDATA_W(DW), .pTIMEOUT(TMO)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .req(req), .req_adr(req_adr),
    .req_wdata(req_wdata), .req_sel(req_sel), .req_we(req_we),
    .done(done), .err(err), .rdata(rdata),
    .wbs_adr(wbs_adr), .wbs_wdata(wbs_wdata), .wbs_sel(wbs_sel),
    .wbs_cyc(wbs_cyc), .wbs_stb(wbs_stb), .wbs_we(wbs_we),
    .wbs_ack(wbs_ack), .wbs_rdata(wbs_rdata)
  );

  always #5 wb_clk = ~wb_clk;

  typedef struct {
    int          g;
    int          stb_n;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        we;
    logic        stable;
    logic        cleared;
    logic        cyc;
    logic [1:0]  done;
    logic [1:0]  err;
    logic [31:0] rdata;
    logic        timed_out;
  } res_t;

  typedef struct {
    int          id;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          dly;
    logic [31:0] srd;
    int          exp_g;
    int          exp_stb;
    logic [31:0] exp_rd;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic load(input int id, input logic we, input logic [31:0] adr,
                      input logic [31:0] wd, input logic [3:0] sel);
    req_adr[id*AW +: AW]   = adr;
    req_wdata[id*DW +: DW] = wd;
    req_sel[id*4 +: 4]     = sel;
    req_we[id]             = we;
    req[id]                = 1'b1;
  endtask

  // Acts as the Wishbone slave for one bus cycle; returns at the negedge that shows DONE.
  task automatic bus_txn(input int dly, input logic [31:0] rd, input int max_stb,
                         input int scr, output res_t r);
    int w;
    r = '{default: 0};
    r.g = -1;
    r.stable = 1'b1;
    w = 0;
    while (wbs_cyc !== 1'b1 && w < 20) begin
      @(negedge wb_clk);
      w++;
    end
    if (wbs_cyc !== 1'b1) begin
      r.timed_out = 1'b1;
      return;
    end
    r.adr = wbs_adr; r.wdata = wbs_wdata; r.sel = wbs_sel; r.we = wbs_we;
    while (wbs_cyc === 1'b1 && r.stb_n < max_stb) begin
      if (wbs_stb !== 1'b1 || wbs_adr !== r.adr || wbs_wdata !== r.wdata ||
          wbs_sel !== r.sel || wbs_we !== r.we) r.stable = 1'b0;
      if (r.stb_n == 0 && scr >= 0) begin
        req[scr] = 1'b0;
        req_adr[scr*AW +: AW]   = $urandom;
        req_wdata[scr*DW +: DW] = $urandom;
        req_sel[scr*4 +: 4]     = 4'($urandom);
        req_we[scr]             = ~req_we[scr];
      end
      if (r.stb_n == dly) begin
        wbs_ack = 1'b1;
        wbs_rdata = rd;
      end
      r.stb_n++;
      @(negedge wb_clk);
      wbs_ack = 1'b0;
      wbs_rdata = $urandom;
    end
    r.cyc = wbs_cyc; r.done = done; r.err = err; r.rdata = rdata;
    r.cleared = (wbs_adr == 0 && wbs_wdata == 0 && wbs_sel == 0 &&
                 wbs_we == 0 && wbs_stb == 0 && wbs_cyc == 0);
    if (done == 2'b01) r.g = 0;
    else if (done == 2'b10) r.g = 1;
  endtask

  task automatic post_done(input bit stray_ack);
    wbs_ack = stray_ack;
    @(negedge wb_clk);
    wbs_ack = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("gap_cyc", wbs_cyc, 0);
  endtask

  task automatic check_txn(input string nm, input res_t r, input int eg, input int estb,
                           input logic [31:0] ea, input logic [31:0] ew, input logic [3:0] es,
                           input logic ewe, input bit chk_rd, input logic [31:0] erd);
    chk({nm, ".started"}, r.timed_out, 0);
    chk({nm, ".grant"}, r.g, eg);
    chk({nm, ".stb_cycles"}, r.stb_n, estb);
    chk({nm, ".adr"}, r.adr, ea);
    chk({nm, ".wdata"}, r.wdata, ew);
    chk({nm, ".sel"}, r.sel, es);
    chk({nm, ".we"}, r.we, ewe);
    chk({nm, ".stable"}, r.stable, 1);
    chk({nm, ".cleared"}, r.cleared, 1);
    chk({nm, ".err"}, r.err, 0);
    if (chk_rd) chk({nm, ".rdata"}, r.rdata, erd);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[5];
    res_t        r;
    int          order[4];
    int          dcnt[2];
    bit          pend[2];
    logic [31:0] m_adr[2];
    logic [31:0] m_wd[2];
    logic [3:0]  m_sel[2];
    logic        m_we[2];
    int          last;
    int          eg;
    int          dly;
    int          scr;
    logic [31:0] rd;

    vt[0] = '{0, 1'b1, FSIC_IS_BASE,        32'h0000_0001, 4'b0001, 2,       32'hdead_beef, 0, 3,   32'h0};
    vt[1] = '{1, 1'b0, FSIC_AA_BASE,        32'h0,         4'b1111, 1,       32'ha5a5_a5a5, 1, 2,   32'ha5a5_a5a5};
    vt[2] = '{0, 1'b0, FSIC_MBOX_BASE,      32'h0,         4'b1111, 0,       32'h1234_5678, 0, 1,   32'h1234_5678};
    vt[3] = '{1, 1'b1, 32'h3000_2004,       32'hcafe_f00d, 4'b1100, 5,       32'h0,         1, 6,   32'h0};
    vt[4] = '{0, 1'b0, FSIC_AA_BASE + 4,    32'h0,         4'b0011, TMO - 1, 32'h0bad_f00d, 0, TMO, 32'h0bad_f00d};

    req = '0; req_adr = '0; req_wdata = '0; req_sel = '0; req_we = '0;
    wbs_ack = 1'b0; wbs_rdata = '0;
    wb_rst = 1'b1;
    #1 wb_rst = 1'b0;
    repeat (2) @(negedge wb_clk);
    chk("rst.cyc", wbs_cyc, 0);
    chk("rst.stb", wbs_stb, 0);
    chk("rst.we", wbs_we, 0);
    chk("rst.adr", wbs_adr, 0);
    chk("rst.done", done, 0);
    chk("rst.err", err, 0);
    chk("rst.rdata", rdata, 0);
    wb_rst = 1'b1;
    @(negedge wb_clk);

    // Both requesters held across two transactions each.
    order = '{0, 1, 0, 1};
    dcnt = '{0, 0};
    load(0, 1'b1, FSIC_MBOX_BASE, 32'h11, 4'hf);
    load(1, 1'b1, FSIC_IS_BASE, 32'h22, 4'hf);
    for (int k = 0; k < 4; k++) begin
      bus_txn(1, $urandom, 30, -1, r);
      chk("rr.started", r.timed_out, 0);
      chk("rr.grant", r.g, order[k]);
      if (r.g >= 0) begin
        dcnt[r.g]++;
        if (dcnt[r.g] == 2) req[r.g] = 1'b0;
      end
      post_done(1'b0);
    end
    req = '0;

    for (int i = 0; i < 5; i++) begin
      load(vt[i].id, vt[i].we, vt[i].adr, vt[i].wdata, vt[i].sel);
      bus_txn(vt[i].dly, vt[i].srd, 30, -1, r);
      check_txn($sformatf("vec%0d", i), r, vt[i].exp_g, vt[i].exp_stb, vt[i].adr,
                vt[i].wdata, vt[i].sel, vt[i].we, !vt[i].we, vt[i].exp_rd);
      req[vt[i].id] = 1'b0;
      post_done(1'b1);
    end

    // Slave never acks.
    load(1, 1'b0, FSIC_IS_BASE + 8, 32'h0, 4'hf);
    bus_txn(-1, 32'h0, 40, -1, r);
`ifdef WB_ACK_TIMEOUT_EN
    chk("tmo.stb_cycles", r.stb_n, TMO);
    chk("tmo.grant", r.g, 1);
    chk("tmo.err", r.err, 2'b10);
    chk("tmo.rdata", r.rdata, 0);
    chk("tmo.cleared", r.cleared, 1);
    req[1] = 1'b0;
    post_done(1'b0);
`else
    chk("noack.stb_cycles", r.stb_n, 40);
    chk("noack.cyc_held", r.cyc, 1);
    chk("noack.done", r.done, 0);
    chk("noack.err", r.err, 0);
`endif

    // Reset in the middle of a bus cycle.
    if (wbs_cyc !== 1'b1) begin
      load(0, 1'b1, FSIC_AA_BASE, 32'h55, 4'hf);
      for (int w = 0; w < 20 && wbs_cyc !== 1'b1; w++) @(negedge wb_clk);
      chk("abort.started", wbs_cyc, 1);
      repeat (2) @(negedge wb_clk);
    end
    #2 wb_rst = 1'b0;
    #1;
    chk("abort.cyc", wbs_cyc, 0);
    chk("abort.stb", wbs_stb, 0);
    chk("abort.we", wbs_we, 0);
    chk("abort.adr", wbs_adr, 0);
    chk("abort.wdata", wbs_wdata, 0);
    chk("abort.sel", wbs_sel, 0);
    chk("abort.rdata", rdata, 0);
    req = '0;
    @(negedge wb_clk);
    chk("abort.no_done", done, 0);
    wb_rst = 1'b1;
    @(negedge wb_clk);
    load(0, 1'b1, FSIC_IS_BASE, 32'h77, 4'b0001);
    load(1, 1'b0, FSIC_AA_BASE, 32'h0, 4'hf);
    bus_txn(2, 32'h0, 30, -1, r);
    check_txn("post_rst0", r, 0, 3, FSIC_IS_BASE, 32'h77, 4'b0001, 1'b1, 1'b0, 32'h0);
    req[0] = 1'b0;
    post_done(1'b0);
    bus_txn(0, 32'h600d_cafe, 30, -1, r);
    check_txn("post_rst1", r, 1, 1, FSIC_AA_BASE, 32'h0, 4'hf, 1'b0, 1'b1, 32'h600d_cafe);
    req[1] = 1'b0;
    post_done(1'b0);

    // Ack with no transaction in flight.
    wbs_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge wb_clk);
      chk("idle_ack.cyc", wbs_cyc, 0);
      chk("idle_ack.done", done, 0);
    end
    wbs_ack = 1'b0;

    // Randomized traffic against a pending-set round-robin model.
    pend = '{0, 0};
    last = 1;
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          m_adr[i] = $urandom; m_wd[i] = $urandom; m_sel[i] = 4'($urandom);
          m_we[i] = 1'($urandom_range(0, 1));
          load(i, m_we[i], m_adr[i], m_wd[i], m_sel[i]);
          pend[i] = 1'b1;
        end
      end
      if (!pend[0] && !pend[1]) begin
        eg = $urandom_range(0, 1);
        m_adr[eg] = $urandom; m_wd[eg] = $urandom; m_sel[eg] = 4'($urandom);
        m_we[eg] = 1'($urandom_range(0, 1));
        load(eg, m_we[eg], m_adr[eg], m_wd[eg], m_sel[eg]);
        pend[eg] = 1'b1;
      end
      eg  = (pend[0] && pend[1]) ? 1 - last : (pend[0] ? 0 : 1);
      dly = $urandom_range(0, 5);
      rd  = $urandom;
      scr = ($urandom_range(0, 3) == 0) ? eg : -1;
      bus_txn(dly, rd, 30, scr, r);
      check_txn($sformatf("rnd%0d", it), r, eg, dly + 1, m_adr[eg], m_wd[eg],
                m_sel[eg], m_we[eg], !m_we[eg], rd);
      req[eg] = 1'b0;
      pend[eg] = 1'b0;
      last = eg;
      post_done(1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
